alu_operand_stage: RTL and testbench

Register-read / operand-issue stage directly upstream of the 32-bit ALU. It holds the 32×32 MIPS general-purpose register file with two read ports and one write port. Each issued instruction has its two operands selected from the register file or a sign-extended immediate. The operands and the 3-bit ALU control code are registered into an output stage that drives the ALU's `a`, `b` and `ctr` inputs. Writeback enters through the single write port.

---
 rtl/alu_operand_pkg.sv | 37 +++
 rtl/alu_operand_stage_if.sv | 51 +++++
 rtl/mips_regfile_core.sv | 44 ++++
 rtl/alu_operand_stage.sv | 96 +++++++++
 tb/tb_alu_operand_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_pkg.sv
// -----------------------------------------------------------------------------
// alu_operand_pkg
//   Shared widths, ALU control codes and register-file constants for the
//   operand-issue stage in front of the 32-bit MIPS ALU.
//
//   Optional feature macro: ALU_OPERAND_BYPASS_EN (used in alu_operand_stage).
// -----------------------------------------------------------------------------
package alu_operand_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // ALU control codes carried on ctr_in / alu_ctr.
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctr_e;

    // r0 is hard-wired to zero.
    localparam addr_t REG_ZERO = '0;

    // True when a writeback this cycle lands on the given read address.
    // r0 is excluded since writes to it are discarded.
    function automatic logic wr_hits(input logic  wr_en,
                                     input addr_t wr_addr,
                                     input addr_t rd_addr);
        return wr_en && (wr_addr != REG_ZERO) && (wr_addr == rd_addr);
    endfunction

endpackage : alu_operand_pkg

// File: rtl/alu_operand_stage_if.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_if
//   Bundles the issue inputs, the writeback port and the registered ALU
//   operand outputs of alu_operand_stage.
//
//   Issue / hold semantics: issue_valid marks an instruction presented this
//   cycle; it is accepted at a rising edge only when stall is 0. While stall
//   is 1 the outputs hold and the issue inputs are ignored (not queued), so
//   the upstream stage must keep presenting the same instruction. op_valid
//   marks that alu_a/alu_b/alu_ctr carry a real operation.
//
//   Modports:
//     master : upstream/testbench side (drives issue + writeback)
//     slave  : the operand stage (drives alu_* and op_valid)
// -----------------------------------------------------------------------------
interface alu_operand_stage_if;
    import alu_operand_pkg::*;

    // Issue side
    logic        issue_valid;
    addr_t       rs_addr;
    addr_t       rt_addr;
    data_t       imm;
    logic        use_imm;
    logic [2:0]  ctr_in;
    logic        stall;

    // Writeback side
    logic        wr_en;
    addr_t       wr_addr;
    data_t       wr_data;

    // Registered ALU inputs
    data_t       alu_a;
    data_t       alu_b;
    logic [2:0]  alu_ctr;
    logic        op_valid;

    modport master (
        output issue_valid, rs_addr, rt_addr, imm, use_imm, ctr_in, stall,
        output wr_en, wr_addr, wr_data,
        input  alu_a, alu_b, alu_ctr, op_valid
    );

    modport slave (
        input  issue_valid, rs_addr, rt_addr, imm, use_imm, ctr_in, stall,
        input  wr_en, wr_addr, wr_data,
        output alu_a, alu_b, alu_ctr, op_valid
    );

endinterface : alu_operand_stage_if

// File: rtl/mips_regfile_core.sv
// -----------------------------------------------------------------------------
// mips_regfile_core
//   32 x 32-bit MIPS general-purpose register file: two asynchronous read
//   ports, one synchronous write port, r0 hard-wired to zero, and an
//   asynchronous active-high reset that clears every entry.
//
//   Ports:
//     clk_i, rst_i           clock, async active-high reset
//     rd0_addr_i/rd0_data_o  read port 0 (combinational)
//     rd1_addr_i/rd1_data_o  read port 1 (combinational)
//     wr_en_i/wr_addr_i/wr_data_i  write port, committed on rising edge
// -----------------------------------------------------------------------------
module mips_regfile_core
    import alu_operand_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  addr_t rd0_addr_i,
    output data_t rd0_data_o,
    input  addr_t rd1_addr_i,
    output data_t rd1_data_o,
    input  logic  wr_en_i,
    input  addr_t wr_addr_i,
    input  data_t wr_data_i
);

    data_t mem_q [NUM_REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != REG_ZERO)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // r0 is forced to zero on the read side as well, so correctness does not
    // depend on entry 0 never being written.
    assign rd0_data_o = (rd0_addr_i == REG_ZERO) ? '0 : mem_q[rd0_addr_i];
    assign rd1_data_o = (rd1_addr_i == REG_ZERO) ? '0 : mem_q[rd1_addr_i];

endmodule : mips_regfile_core

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//   Register-read / operand-issue stage in front of the 32-bit ALU. Reads two
//   operands from the register file (or takes the sign-extended immediate for
//   operand B), and registers them together with the ALU control code.
//   Outputs are pure registers; a stall holds them.
//
//   Configuration macro: ALU_OPERAND_BYPASS_EN
//     defined   : a writeback to a register being read at the same edge is
//                 forwarded into the operand register (write-through).
//     undefined : operand registers take the pre-write register contents.
//
//   Ports:
//     clk  clock (rising edge)
//     rst  asynchronous active-high reset
//     bus  alu_operand_stage_if.slave (issue, writeback, ALU operand outputs)
// -----------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  bus
);

    data_t rs_rdata;
    data_t rt_rdata;
    data_t src_a;
    data_t src_b_reg;

    data_t      alu_a_q,    alu_a_d;
    data_t      alu_b_q,    alu_b_d;
    logic [2:0] alu_ctr_q,  alu_ctr_d;
    logic       op_valid_q, op_valid_d;

    mips_regfile_core u_regfile (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd0_addr_i (bus.rs_addr),
        .rd0_data_o (rs_rdata),
        .rd1_addr_i (bus.rt_addr),
        .rd1_data_o (rt_rdata),
        .wr_en_i    (bus.wr_en),
        .wr_addr_i  (bus.wr_addr),
        .wr_data_i  (bus.wr_data)
    );

    // Operand source selection, with optional same-edge write forwarding.
    always_comb begin
        src_a     = rs_rdata;
        src_b_reg = rt_rdata;
`ifdef ALU_OPERAND_BYPASS_EN
        if (wr_hits(bus.wr_en, bus.wr_addr, bus.rs_addr)) begin
            src_a = bus.wr_data;
        end
        if (wr_hits(bus.wr_en, bus.wr_addr, bus.rt_addr)) begin
            src_b_reg = bus.wr_data;
        end
`endif
    end

    // Output stage next-state: hold on stall, otherwise load every cycle.
    // On a bubble the operand registers still load; only op_valid matters.
    always_comb begin
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctr_d  = alu_ctr_q;
        op_valid_d = op_valid_q;
        if (!bus.stall) begin
            alu_a_d    = src_a;
            alu_b_d    = bus.use_imm ? bus.imm : src_b_reg;
            alu_ctr_d  = bus.ctr_in;
            op_valid_d = bus.issue_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctr_q  <= ALU_AND;
            op_valid_q <= 1'b0;
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctr_q  <= alu_ctr_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_ctr  = alu_ctr_q;
    assign bus.op_valid = op_valid_q;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//   Directed scenarios followed by randomized traffic for alu_operand_stage.
//   A behavioural model (register array + expected output values) tracks the
//   DUT; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;
    import alu_operand_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_ctr;
    logic        m_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("compare %s", tag);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_a   = 32'h0;
        m_b   = 32'h0;
        m_ctr = 3'b000;
        m_v   = 1'b0;
    endtask

    // Value an operand register should capture for a read of 'addr' at this edge.
    function automatic logic [31:0] operand(input logic [4:0] addr);
        logic [31:0] v;
        v = (addr == 5'd0) ? 32'h0 : m_rf[addr];
`ifdef ALU_OPERAND_BYPASS_EN
        if (bus.wr_en && bus.wr_addr != 5'd0 && bus.wr_addr == addr) v = bus.wr_data;
`endif
        return v;
    endfunction

    task automatic model_edge();
        if (!bus.stall) begin
            m_a   = operand(bus.rs_addr);
            m_b   = bus.use_imm ? bus.imm : operand(bus.rt_addr);
            m_ctr = bus.ctr_in;
            m_v   = bus.issue_valid;
        end
        if (bus.wr_en && bus.wr_addr != 5'd0) m_rf[bus.wr_addr] = bus.wr_data;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".op_valid"}, {31'b0, bus.op_valid}, {31'b0, m_v});
        if (m_v) begin
            check({tag, ".alu_a"},   bus.alu_a, m_a);
            check({tag, ".alu_b"},   bus.alu_b, m_b);
            check({tag, ".alu_ctr"}, {29'b0, bus.alu_ctr}, {29'b0, m_ctr});
        end
    endtask

    // One clock: model follows the rising edge, outputs checked at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] im, input logic ui, input logic [2:0] ctr);
        bus.issue_valid = v;
        bus.rs_addr     = rs;
        bus.rt_addr     = rt;
        bus.imm         = im;
        bus.use_imm     = ui;
        bus.ctr_in      = ctr;
    endtask

    task automatic write(input logic en, input logic [4:0] addr, input logic [31:0] data);
        bus.wr_en   = en;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_a"},    bus.alu_a, 32'h0);
        check({tag, ".alu_b"},    bus.alu_b, 32'h0);
        check({tag, ".alu_ctr"},  {29'b0, bus.alu_ctr}, 32'h0);
        check({tag, ".op_valid"}, {31'b0, bus.op_valid}, 32'h0);
    endtask

    initial begin
        bus.stall = 1'b0;
        issue(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'b000);
        write(1'b0, 5'd0, 32'h0);
        model_reset();

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Add operands
        write(1'b1, 5'd1, 32'h00001111);
        tick("wr_r1");
        write(1'b1, 5'd2, 32'h11110000);
        tick("wr_r2");
        write(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd1, 5'd2, 32'h0, 1'b0, ALU_ADD);
        tick("add");
        check("add.a",   bus.alu_a, 32'h00001111);
        check("add.b",   bus.alu_b, 32'h11110000);
        check("add.ctr", {29'b0, bus.alu_ctr}, 32'd2);
        check("add.v",   {31'b0, bus.op_valid}, 32'd1);

        // Immediate subtract
        issue(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, ALU_AND);
        write(1'b1, 5'd3, 32'hFFFFFEE8);
        tick("wr_r3");
        write(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd3, 5'd0, 32'h00000071, 1'b1, ALU_SUB);
        tick("subi");
        check("subi.a",   bus.alu_a, 32'hFFFFFEE8);
        check("subi.b",   bus.alu_b, 32'h00000071);
        check("subi.ctr", {29'b0, bus.alu_ctr}, 32'd6);

        // r0 protection
        issue(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, ALU_AND);
        write(1'b1, 5'd0, 32'hDEADBEEF);
        tick("wr_r0");
        write(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd0, 5'd0, 32'h0, 1'b0, ALU_OR);
        tick("r0");
        check("r0.a", bus.alu_a, 32'h0);
        check("r0.b", bus.alu_b, 32'h0);

        // Stall holds outputs while inputs and r1 change
        issue(1'b1, 5'd1, 5'd2, 32'h0, 1'b0, ALU_ADD);
        tick("pre_stall");
        check("pre_stall.a", bus.alu_a, 32'h00001111);
        bus.stall = 1'b1;
        issue(1'b1, 5'd2, 5'd1, 32'h0, 1'b0, ALU_OR);
        write(1'b1, 5'd1, 32'h0000000F);
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.a",   bus.alu_a, 32'h00001111);
            check("stall.ctr", {29'b0, bus.alu_ctr}, 32'd2);
        end
        bus.stall = 1'b0;
        write(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd1, 5'd2, 32'h0, 1'b0, ALU_SLT);
        tick("post_stall");
        check("post_stall.a", bus.alu_a, 32'h0000000F);
        check("post_stall.b", bus.alu_b, 32'h11110000);

        // Same-edge write/read hazard
        issue(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, ALU_AND);
        write(1'b1, 5'd4, 32'h00000384);
        tick("wr_r4");
        write(1'b1, 5'd4, 32'h00000001);
        issue(1'b1, 5'd4, 5'd4, 32'h0, 1'b0, ALU_ADD);
        tick("hazard");
`ifdef ALU_OPERAND_BYPASS_EN
        check("hazard.a", bus.alu_a, 32'h00000001);
`else
        check("hazard.a", bus.alu_a, 32'h00000384);
`endif
        write(1'b0, 5'd0, 32'h0);
        tick("hazard_next");
        check("hazard_next.a", bus.alu_a, 32'h00000001);

        // Randomized traffic; small address range so reads hit recent writes
        for (int n = 0; n < 400; n++) begin
            bus.stall = ($urandom_range(0, 3) == 0);
            issue($urandom_range(0, 4) != 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
            write($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            tick("rand");
        end

        // Mid-operation asynchronous reset
        bus.stall = 1'b0;
        write(1'b1, 5'd1, 32'h12345678);
        issue(1'b1, 5'd1, 5'd2, 32'h0, 1'b0, ALU_ADD);
        tick("b2b0");
        issue(1'b1, 5'd2, 5'd1, 32'h0, 1'b0, ALU_SUB);
        tick("b2b1");
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        #1 rst = 1'b0;
        write(1'b0, 5'd0, 32'h0);
        issue(1'b0, 5'd1, 5'd1, 32'h0, 1'b0, ALU_ADD);
        tick("post_rst_idle");
        check("post_rst_idle.v", {31'b0, bus.op_valid}, 32'd0);
        issue(1'b1, 5'd1, 5'd1, 32'h0, 1'b0, ALU_ADD);
        tick("post_rst_issue");
        check("post_rst.a", bus.alu_a, 32'h0);
        check("post_rst.v", {31'b0, bus.op_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_alu_operand_stage
